// File: rtl/td4_core_pkg.sv
// rtl/td4_core_pkg.sv - TD4 opcode macros, widths and architectural state record
`ifndef TD4_DEFINE_OPCODE
`define TD4_DEFINE_OPCODE
`define OP_ADD_A  4'b0000
`define OP_MOV_AB 4'b0001
`define OP_IN_A   4'b0010
`define OP_MOV_AI 4'b0011
`define OP_MOV_BA 4'b0100
`define OP_ADD_B  4'b0101
`define OP_IN_B   4'b0110
`define OP_MOV_BI 4'b0111
`define OP_OUT_B  4'b1001
`define OP_OUT_I  4'b1011
`define OP_JNC    4'b1110
`define OP_JMP    4'b1111
`endif

package td4_core_pkg;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 4;
    localparam int INSN_W = 8;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] out_q;
        logic [ADDR_W-1:0] pc;
        logic              c;
    } td4_state_t;

endpackage

// File: rtl/td4_alu.sv
// rtl/td4_alu.sv - combinational 4-bit adder producing {carry, sum}
module td4_alu
    import td4_core_pkg::*;
(
    input  logic [DATA_W-1:0] operand,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] sum,
    output logic              carry
);

    assign {carry, sum} = {1'b0, operand} + {1'b0, imm};

endmodule

// File: rtl/td4_core.sv
// rtl/td4_core.sv - single-cycle TD4 execution core fetching from a combinational ROM
module td4_core
    import td4_core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INSN_W-1:0] rom_data,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic              carry,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b
);

    td4_state_t        st;
    td4_state_t        nxt;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] alu_operand;
    logic [DATA_W-1:0] alu_sum;
    logic              alu_carry;

    assign opcode      = rom_data[7:4];
    assign imm         = rom_data[3:0];
    assign alu_operand = (opcode == `OP_ADD_B) ? st.b : st.a;

    td4_alu u_alu (
        .operand (alu_operand),
        .imm     (imm),
        .sum     (alu_sum),
        .carry   (alu_carry)
    );

    // Every instruction rewrites carry; unknown or X opcodes fall to the NOP default.
    always_comb begin
        nxt    = st;
        nxt.pc = st.pc + 4'd1;
        nxt.c  = 1'b0;
        case (opcode)
            `OP_ADD_A:  begin nxt.a = alu_sum; nxt.c = alu_carry; end
            `OP_MOV_AB: nxt.a = st.b;
            `OP_IN_A:   nxt.a = in_port;
            `OP_MOV_AI: nxt.a = imm;
            `OP_MOV_BA: nxt.b = st.a;
            `OP_ADD_B:  begin nxt.b = alu_sum; nxt.c = alu_carry; end
            `OP_IN_B:   nxt.b = in_port;
            `OP_MOV_BI: nxt.b = imm;
            `OP_OUT_B:  nxt.out_q = st.b;
            `OP_OUT_I:  nxt.out_q = imm;
            `OP_JNC:    if (!st.c) nxt.pc = imm;
            `OP_JMP:    nxt.pc = imm;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= '0;
        end else if (en) begin
            st <= nxt;
        end
    end

    assign rom_addr = st.pc;
    assign out_port = st.out_q;
    assign carry    = st.c;
    assign reg_a    = st.a;
    assign reg_b    = st.b;

endmodule

// File: tb/tb_td4_core.sv
// tb/tb_td4_core.sv - directed vector bench for td4_core with a behavioural program ROM
module tb_td4_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] in_port = 4'd0;
    logic [3:0] out_port;
    logic       carry;
    logic [3:0] reg_a;
    logic [3:0] reg_b;

    logic [7:0] rom [16];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    td4_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .in_port  (in_port),
        .out_port (out_port),
        .carry    (carry),
        .reg_a    (reg_a),
        .reg_b    (reg_b)
    );

    typedef struct {
        string      name;
        int         cycles;
        logic [3:0] inp;
        logic [7:0] head [6];
        logic [7:0] fill;
        logic [3:0] ea;
        logic [3:0] eb;
        logic       ec;
        logic [3:0] epc;
        logic [3:0] eout;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_all(input string name, input logic [3:0] ea, input logic [3:0] eb,
                           input logic ec, input logic [3:0] epc, input logic [3:0] eout);
        chk({name, ".a"},   reg_a,           ea);
        chk({name, ".b"},   reg_b,           eb);
        chk({name, ".c"},   {3'b000, carry}, {3'b000, ec});
        chk({name, ".pc"},  rom_addr,        epc);
        chk({name, ".out"}, out_port,        eout);
    endtask

    task automatic set_vec(input int i, input string name, input int cycles, input logic [3:0] inp,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                           input logic [7:0] fill, input logic [3:0] ea, input logic [3:0] eb,
                           input logic ec, input logic [3:0] epc, input logic [3:0] eout);
        vecs[i].name    = name;
        vecs[i].cycles  = cycles;
        vecs[i].inp     = inp;
        vecs[i].head[0] = b0;
        vecs[i].head[1] = b1;
        vecs[i].head[2] = b2;
        vecs[i].head[3] = b3;
        vecs[i].head[4] = b4;
        vecs[i].head[5] = b5;
        vecs[i].fill    = fill;
        vecs[i].ea      = ea;
        vecs[i].eb      = eb;
        vecs[i].ec      = ec;
        vecs[i].epc     = epc;
        vecs[i].eout    = eout;
    endtask

    // Reset is applied mid-cycle, the program loaded, then released before the next edge.
    task automatic load_and_reset(input logic [7:0] head [6], input logic [7:0] fill);
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b1;
        for (int k = 0; k < 16; k++) rom[k] = (k < 6) ? head[k] : fill;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] prog [6];

    initial begin
        for (int k = 0; k < 16; k++) rom[k] = 8'h80;

        set_vec(0,  "addmov",      6, 4'h0, 8'h30, 8'h0A, 8'h74, 8'h51, 8'h10, 8'hF5, 8'h80, 4'h5, 4'h5, 1'b0, 4'h5, 4'h0);
        set_vec(1,  "addmov_halt", 12, 4'h0, 8'h30, 8'h0A, 8'h74, 8'h51, 8'h10, 8'hF5, 8'h80, 4'h5, 4'h5, 1'b0, 4'h5, 4'h0);
        set_vec(2,  "jnc_not",     3, 4'h0, 8'h3E, 8'h01, 8'hE4, 8'h80, 8'h80, 8'h80, 8'h80, 4'hF, 4'h0, 1'b0, 4'h4, 4'h0);
        set_vec(3,  "carry_set",   2, 4'h0, 8'h3F, 8'h01, 8'hE4, 8'h30, 8'h80, 8'h80, 8'h80, 4'h0, 4'h0, 1'b1, 4'h2, 4'h0);
        set_vec(4,  "jnc_taken",   3, 4'h0, 8'h3F, 8'h01, 8'hE4, 8'h30, 8'h80, 8'h80, 8'h80, 4'h0, 4'h0, 1'b0, 4'h3, 4'h0);
        set_vec(5,  "mov_clr_c",   4, 4'h0, 8'h3F, 8'h01, 8'hE4, 8'h30, 8'h80, 8'h80, 8'h80, 4'h0, 4'h0, 1'b0, 4'h4, 4'h0);
        set_vec(6,  "io_outb",     2, 4'hB, 8'h60, 8'h90, 8'hB6, 8'h80, 8'h80, 8'h80, 8'h80, 4'h0, 4'hB, 1'b0, 4'h2, 4'hB);
        set_vec(7,  "io_outim",    3, 4'hB, 8'h60, 8'h90, 8'hB6, 8'h80, 8'h80, 8'h80, 8'h80, 4'h0, 4'hB, 1'b0, 4'h3, 4'h6);
        set_vec(8,  "in_a_movba",  2, 4'h9, 8'h20, 8'h40, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 4'h9, 4'h9, 1'b0, 4'h2, 4'h0);
        set_vec(9,  "addb_wrap",   2, 4'h0, 8'h7F, 8'h51, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 4'h0, 4'h0, 1'b1, 4'h2, 4'h0);
        set_vec(10, "undef_nop",   5, 4'h0, 8'h37, 8'h0F, 8'hA3, 8'hC3, 8'hD3, 8'hF5, 8'h80, 4'h6, 4'h0, 1'b0, 4'h5, 4'h0);
        set_vec(11, "nop16_wrap",  16, 4'h0, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        set_vec(12, "nop15",       15, 4'h0, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 4'h0, 4'h0, 1'b0, 4'hF, 4'h0);
        set_vec(13, "wrap_keep",   16, 4'h0, 8'h37, 8'h75, 8'hB9, 8'h80, 8'h80, 8'h80, 8'h80, 4'h7, 4'h5, 1'b0, 4'h0, 4'h9);
        set_vec(14, "self_jump",   10, 4'h0, 8'h3F, 8'h0F, 8'hF2, 8'h80, 8'h80, 8'h80, 8'h80, 4'hE, 4'h0, 1'b0, 4'h2, 4'h0);

        #1;
        chk_all("por", 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);

        for (int i = 0; i < 15; i++) begin
            in_port = vecs[i].inp;
            load_and_reset(vecs[i].head, vecs[i].fill);
            run(vecs[i].cycles);
            chk_all(vecs[i].name, vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].epc, vecs[i].eout);
        end

        // Enable low holds everything, including a pending carry consumed by JNC afterwards.
        prog[0] = 8'hB7; prog[1] = 8'h3F; prog[2] = 8'h01;
        prog[3] = 8'hE0; prog[4] = 8'h80; prog[5] = 8'h80;
        load_and_reset(prog, 8'h80);
        run(3);
        chk_all("pre_hold", 4'h0, 4'h0, 1'b1, 4'h3, 4'h7);
        en = 1'b0;
        run(3);
        chk_all("en_hold", 4'h0, 4'h0, 1'b1, 4'h3, 4'h7);
        en = 1'b1;
        run(1);
        chk_all("after_hold", 4'h0, 4'h0, 1'b0, 4'h4, 4'h7);

        // Asynchronous reset between edges clears state before any clock, then restarts at 0.
        prog[0] = 8'h30; prog[1] = 8'h0A; prog[2] = 8'h74;
        prog[3] = 8'h51; prog[4] = 8'h10; prog[5] = 8'hF5;
        load_and_reset(prog, 8'h80);
        run(3);
        chk_all("pre_reset", 4'hA, 4'h4, 1'b0, 4'h3, 4'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        rst_n = 1'b1;
        run(1);
        chk_all("restart", 4'h0, 4'h0, 1'b0, 4'h1, 4'h0);
        run(1);
        chk_all("restart2", 4'hA, 4'h0, 1'b0, 4'h2, 4'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
